t03_vertical_counter: RTL and testbench
=======================================

# t03_vertical_counter

Line- and frame-level timing stage directly downstream of the horizontal counter in the team_03 display path. Consumes the horizontal count and its end-of-line terminal count, counts scan lines, and runs a vertical-phase state machine (active, front porch, sync, back porch). Produces registered hsync/vsync, display-enable, pixel coordinates and a start-of-frame pulse for the framebuffer read logic.

## Interface
Parameters:
- H_ACTIVE, 160: visible pixels per line (Hcnt 0..159)
- H_FP, 8: horizontal front porch counts
- H_SYNC, 16: horizontal sync width in counts
- H_TOTAL, 209: counts per line; must equal the horizontal counter's period (0..208)
- V_ACTIVE, 600: visible lines
- V_FP, 1: vertical front porch lines
- V_SYNC, 4: vertical sync lines
- V_BP, 23: vertical back porch lines (V_TOTAL = 628)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- h_tc  in  1  end-of-line terminal count from horizontal counter
- Hcnt  in  11  current horizontal count
- Vcnt  out  10  current line, 0..V_TOTAL-1
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- display_en  out  1  high while pixel is visible
- pixel_x  out  11  registered Hcnt, valid when display_en
- frame_start  out  1  one-cycle pulse when Vcnt wraps to 0

## Operation
- Line advance: rising edge of h_tc only (h_tc & ~h_tc_q); h_tc held high for N cycles counts one line.
- Vcnt increments on each line advance; at Vcnt == V_TOTAL-1 it wraps to 0.
- Vertical FSM, advanced only on line advance:
  - V_ACT (Vcnt 0..V_ACTIVE-1) -> V_FPORCH at Vcnt == V_ACTIVE-1
  - V_FPORCH -> V_SYNCP after V_FP lines
  - V_SYNCP -> V_BPORCH after V_SYNC lines
  - V_BPORCH -> V_ACT on wrap to 0
  - State is a pure function of the next Vcnt; illegal encoding recovers to V_ACT with Vcnt forced to 0 on next line advance.
- vsync_n = 0 iff state == V_SYNCP.
- hsync_n = 0 iff H_ACTIVE+H_FP <= Hcnt < H_ACTIVE+H_FP+H_SYNC (counts 168..183).
- display_en = 1 iff state == V_ACT and Hcnt < H_ACTIVE.
- Hcnt >= H_TOTAL (out of range): treated as blanking; display_en = 0, hsync_n = 1.
- frame_start = 1 for exactly one cycle on the edge Vcnt goes V_TOTAL-1 -> 0.

## Timing
- Reset (nrst low, async): Vcnt = 0, state V_ACT, hsync_n = 1, vsync_n = 1, display_en = 0, pixel_x = 0, frame_start = 0, h_tc_q = 0.
- First h_tc rise after reset counts as line advance (Vcnt 0 -> 1).
- Vcnt, state, vsync_n, frame_start update on the same edge that samples the h_tc rise (zero added latency relative to h_tc).
- hsync_n, display_en, pixel_x are registered decodes of Hcnt: one cycle latency, all three mutually aligned.
- display_en uses the state after the update on the same edge, so the first visible pixel of line 0 follows the wrap.
- Reset asserted mid-frame: all outputs go to reset values immediately; counting resumes from line 0.

## Configuration
- T03_FRAME_IRQ_EN defined: adds ports frame_irq (out, 1) and irq_clr (in, 1). frame_irq sets on frame_start, holds until irq_clr; simultaneous set and clear -> set wins. Reset value 0.
- Not defined: ports absent; frame_start is the only frame indication.

## Structure
- Shared package t03_disp_pkg: vertical-state enum (V_ACT, V_FPORCH, V_SYNCP, V_BPORCH), default timing localparams, count widths.
- One sub-module: t03_sync_decode (combinational Hcnt/state -> hsync_n/display_en window compare), instanced once; registers stay in top.

## Test plan
- Reset mid-frame at Vcnt = 300 -> all outputs at reset values same cycle; after release first h_tc rise -> Vcnt = 1.
- 628 h_tc pulses from reset -> frame_start pulses once, Vcnt = 0, state V_ACT; vsync_n low for exactly Vcnt 601..604.
- Sweep Hcnt 0..208 at Vcnt = 10 -> display_en high for 160 cycles, hsync_n low for 16 cycles (Hcnt 168..183), both one cycle after Hcnt.
- h_tc held high 5 cycles -> Vcnt advances by exactly 1.
- Hcnt = 300 injected -> display_en = 0, hsync_n = 1.
- T03_FRAME_IRQ_EN: frame_start with irq_clr high same cycle -> frame_irq = 1; irq_clr next cycle -> frame_irq = 0.

Source files
------------

// File: rtl/t03_disp_pkg.sv
// Shared display-timing package for the team_03 display path: vertical
// phase enum, default timing constants, count widths and the helper that
// maps a line number onto its vertical phase.
package t03_disp_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;

    localparam int DEF_H_ACTIVE = 160;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_H_SYNC   = 16;
    localparam int DEF_H_TOTAL  = 209;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    typedef enum logic [1:0] {
        V_ACT    = 2'd0,
        V_FPORCH = 2'd1,
        V_SYNCP  = 2'd2,
        V_BPORCH = 2'd3
    } vstate_t;

    // Vertical phase is a pure function of the line number.
    function automatic vstate_t vstate_of(input int v, input int v_active,
                                          input int v_fp, input int v_sync);
        if (v < v_active)
            return V_ACT;
        else if (v < v_active + v_fp)
            return V_FPORCH;
        else if (v < v_active + v_fp + v_sync)
            return V_SYNCP;
        else
            return V_BPORCH;
    endfunction

endpackage

// File: rtl/t03_sync_decode.sv
// Combinational window compare: horizontal count plus vertical phase to
// hsync_n / display_en. Counts at or beyond H_TOTAL are treated as blanking.
module t03_sync_decode
    import t03_disp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_TOTAL  = DEF_H_TOTAL
) (
    input  logic [H_W-1:0] hcnt,
    input  vstate_t        vstate,
    output logic           hsync_n,
    output logic           display_en
);

    localparam logic [H_W-1:0] HACT_END = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] HTOT     = H_W'(H_TOTAL);

    logic in_range;

    // Window compares, gated so an out-of-range count never shows sync or video.
    always_comb begin
        in_range   = (hcnt < HTOT);
        hsync_n    = ~(in_range && (hcnt >= HS_START) && (hcnt < HS_END));
        display_en = in_range && (vstate == V_ACT) && (hcnt < HACT_END);
    end

endmodule

// File: rtl/t03_vertical_counter.sv
// Vertical line counter and vertical-phase FSM for the team_03 display path.
// Counts lines on rising edges of h_tc, produces registered sync, display
// enable, pixel_x and a start-of-frame pulse.
// Optional feature macro: T03_FRAME_IRQ_EN adds a sticky frame_irq output
// with an irq_clr input.
module t03_vertical_counter
    import t03_disp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           h_tc,
    input  logic [H_W-1:0] Hcnt,
    output logic [V_W-1:0] Vcnt,
    output logic           hsync_n,
    output logic           vsync_n,
    output logic           display_en,
    output logic [H_W-1:0] pixel_x,
    output logic           frame_start
`ifdef T03_FRAME_IRQ_EN
    ,
    output logic           frame_irq,
    input  logic           irq_clr
`endif
);

    localparam int             V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);

    logic           h_tc_q;
    vstate_t        vstate;
    logic           line_adv;
    logic [V_W-1:0] vcnt_next;
    vstate_t        state_next;
    logic           wrap_next;
    logic           dec_hsync_n;
    logic           dec_display_en;

    assign line_adv = h_tc & ~h_tc_q;

    // Next line number and phase; the phase is always derived from the
    // next line so state and Vcnt can never disagree.
    always_comb begin
        vcnt_next = Vcnt;
        wrap_next = 1'b0;
        if (line_adv) begin
            case (vstate)
                V_ACT, V_FPORCH, V_SYNCP, V_BPORCH: begin
                    if (Vcnt >= V_LAST) begin
                        vcnt_next = '0;
                        wrap_next = (Vcnt == V_LAST);
                    end else begin
                        vcnt_next = Vcnt + V_W'(1);
                    end
                end
                default: vcnt_next = '0;
            endcase
        end
        state_next = vstate_of(int'(vcnt_next), V_ACTIVE, V_FP, V_SYNC);
    end

    // Decode uses the post-update phase so line 0 video follows the wrap.
    t03_sync_decode #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_TOTAL  (H_TOTAL)
    ) u_sync_decode (
        .hcnt       (Hcnt),
        .vstate     (state_next),
        .hsync_n    (dec_hsync_n),
        .display_en (dec_display_en)
    );

    // Line counter, phase register and all registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            h_tc_q      <= 1'b0;
            Vcnt        <= '0;
            vstate      <= V_ACT;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
            hsync_n     <= 1'b1;
            display_en  <= 1'b0;
            pixel_x     <= '0;
        end else begin
            h_tc_q      <= h_tc;
            Vcnt        <= vcnt_next;
            vstate      <= state_next;
            vsync_n     <= (state_next != V_SYNCP);
            frame_start <= wrap_next;
            hsync_n     <= dec_hsync_n;
            display_en  <= dec_display_en;
            pixel_x     <= Hcnt;
        end
    end

`ifdef T03_FRAME_IRQ_EN
    // Sticky frame interrupt; a new frame wins over a simultaneous clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            frame_irq <= 1'b0;
        else if (wrap_next)
            frame_irq <= 1'b1;
        else if (irq_clr)
            frame_irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_t03_vertical_counter.sv
// Directed bench for t03_vertical_counter: reset values, line advance on
// h_tc edges, horizontal sweep, out-of-range Hcnt, mid-frame reset and a
// full frame with vsync / frame_start tracking.
// Define T03_FRAME_IRQ_EN to also exercise frame_irq / irq_clr.
module tb_t03_vertical_counter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        h_tc = 1'b0;
    logic [10:0] Hcnt = '0;
    logic [9:0]  Vcnt;
    logic        hsync_n;
    logic        vsync_n;
    logic        display_en;
    logic [10:0] pixel_x;
    logic        frame_start;
`ifdef T03_FRAME_IRQ_EN
    logic        frame_irq;
    logic        irq_clr = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    t03_vertical_counter dut (
        .clk         (clk),
        .nrst        (nrst),
        .h_tc        (h_tc),
        .Hcnt        (Hcnt),
        .Vcnt        (Vcnt),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .display_en  (display_en),
        .pixel_x     (pixel_x),
        .frame_start (frame_start)
`ifdef T03_FRAME_IRQ_EN
        ,
        .frame_irq   (frame_irq),
        .irq_clr     (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One line: h_tc high one cycle, low one cycle. Counts frame_start seen.
    int fs_seen = 0;
    task automatic pulse();
        h_tc = 1'b1;
        tick();
        if (frame_start === 1'b1) fs_seen++;
        h_tc = 1'b0;
        tick();
        if (frame_start === 1'b1) fs_seen++;
    endtask

    initial begin
        logic exp_de;
        logic exp_hs;
        int   de_cnt;
        int   hs_cnt;
        int   vs_cnt;

        // Reset state
        tick();
        tick();
        check("rst_vcnt", Vcnt, 0);
        check("rst_hsync", hsync_n, 1);
        check("rst_vsync", vsync_n, 1);
        check("rst_de", display_en, 0);
        check("rst_px", pixel_x, 0);
        check("rst_fs", frame_start, 0);

        nrst = 1'b1;
        tick();
        check("de_line0_h0", display_en, 1);

        // First h_tc rise after reset counts a line
        h_tc = 1'b1;
        tick();
        check("first_adv", Vcnt, 1);
        h_tc = 1'b0;
        tick();

        // h_tc held for 5 cycles counts exactly one line
        h_tc = 1'b1;
        tick();
        check("hold_adv_1st", Vcnt, 2);
        for (int i = 0; i < 4; i++) tick();
        check("hold_adv_5th", Vcnt, 2);
        h_tc = 1'b0;
        tick();
        check("hold_release", Vcnt, 2);

        // Advance to line 10
        for (int i = 0; i < 8; i++) pulse();
        check("vcnt_10", Vcnt, 10);

        // Horizontal sweep at line 10
        exp_de = 1'b1;
        exp_hs = 1'b1;
        de_cnt = 0;
        hs_cnt = 0;
        for (int h = 0; h < 209; h++) begin
            Hcnt = 11'(h);
            #1;
            check("lat_de", display_en, exp_de);
            check("lat_hs", hsync_n, exp_hs);
            tick();
            exp_de = (h < 160);
            exp_hs = !((h >= 168) && (h < 184));
            check($sformatf("de_h%0d", h), display_en, exp_de);
            check($sformatf("hs_h%0d", h), hsync_n, exp_hs);
            check($sformatf("px_h%0d", h), pixel_x, h);
            if (display_en === 1'b1) de_cnt++;
            if (hsync_n === 1'b0) hs_cnt++;
        end
        check("de_count", de_cnt, 160);
        check("hs_count", hs_cnt, 16);

        // Out-of-range horizontal counts are blanking
        Hcnt = 11'd300;
        tick();
        check("oor300_de", display_en, 0);
        check("oor300_hs", hsync_n, 1);
        check("oor300_px", pixel_x, 300);
        Hcnt = 11'd2047;
        tick();
        check("oor2047_de", display_en, 0);
        check("oor2047_hs", hsync_n, 1);

        // Move to line 300 with visible pixels, then reset mid-frame
        Hcnt = 11'd5;
        for (int i = 0; i < 290; i++) pulse();
        check("vcnt_300", Vcnt, 300);
        check("de_line300", display_en, 1);
        check("px_line300", pixel_x, 5);
        nrst = 1'b0;
        #1;
        check("mrst_vcnt", Vcnt, 0);
        check("mrst_de", display_en, 0);
        check("mrst_px", pixel_x, 0);
        check("mrst_hs", hsync_n, 1);
        check("mrst_vs", vsync_n, 1);
        check("mrst_fs", frame_start, 0);
        Hcnt = 11'd0;
        tick();
        nrst = 1'b1;
        tick();
        check("mrst_hold", Vcnt, 0);

        // Full frame: 627 lines, then the wrapping line by hand
        fs_seen = 0;
        vs_cnt = 0;
        for (int i = 1; i < 628; i++) begin
            h_tc = 1'b1;
            tick();
            check($sformatf("frm_vcnt%0d", i), Vcnt, i);
            check($sformatf("frm_vs%0d", i), vsync_n, !((i >= 601) && (i <= 604)));
            check($sformatf("frm_de%0d", i), display_en, (i < 600));
            if (vsync_n === 1'b0) vs_cnt++;
            if (frame_start === 1'b1) fs_seen++;
            h_tc = 1'b0;
            tick();
            if (frame_start === 1'b1) fs_seen++;
        end
        check("vs_count", vs_cnt, 4);
        check("fs_before_wrap", fs_seen, 0);

        h_tc = 1'b1;
`ifdef T03_FRAME_IRQ_EN
        irq_clr = 1'b1;
`endif
        tick();
        check("wrap_vcnt", Vcnt, 0);
        check("wrap_fs", frame_start, 1);
        check("wrap_vs", vsync_n, 1);
        check("wrap_de", display_en, 1);
`ifdef T03_FRAME_IRQ_EN
        check("irq_set_wins", frame_irq, 1);
`endif
        h_tc = 1'b0;
        tick();
        check("fs_one_cycle", frame_start, 0);
`ifdef T03_FRAME_IRQ_EN
        check("irq_cleared", frame_irq, 0);
        irq_clr = 1'b0;
`endif
        pulse();
        check("after_wrap_vcnt", Vcnt, 1);
        check("fs_total", fs_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
